spi_slave_bridge_p: RTL and testbench
=====================================

Name: spi_slave_bridge_p

Overview:
Parametrised SPI slave bridge that replaces the fixed 8-bit, mode-0-only bridge between the external SPI master and the internal register decoder.
- Supports all four SPI modes, configurable word width and bit order.
- Synchronises the SPI inputs into the peripheral clock domain.
- Reports partial (aborted) frames.
- Presents received words and requests transmit words with single-cycle strobes on the clk domain.

Parameters:
DATA_W, 8, word width in bits (2..32)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge / shift on trailing; 1 = shift on leading / sample on trailing
MSB_FIRST, 1, 1 = MSB first on both MOSI and MISO; 0 = LSB first
SYNC_STAGES, 2, synchroniser depth for sclk/cs_n/mosi (2..4)

Ports:
clk  in  1  peripheral clock
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock (asynchronous)
cs_n  in  1  SPI chip select, active low (asynchronous)
mosi  in  1  master-out data (asynchronous)
miso  out  1  slave-out data, registered
miso_oe  out  1  1 while frame active, for pad tri-state
word_sync  out  1  one-cycle pulse: data_in holds a new complete word
data_in  out  DATA_W  last complete received word
data_out  in  DATA_W  word to transmit, captured on tx_req
tx_req  out  1  one-cycle pulse: data_out captured this cycle
frame_abort  out  1  one-cycle pulse: cs_n deasserted with partial word

Behaviour:
- Single clock domain clk; asynchronous active-low reset rst_n.
- Reset values:
  - miso = 0, miso_oe = 0, word_sync = 0, tx_req = 0, frame_abort = 0, data_in = 0.
  - Bit counter = 0, state = IDLE.
  - Synchroniser flops: sclk stages = CPOL, cs_n stages = 1, mosi stages = 0.
- Edge detection:
  - The last two synchroniser stages give the synced level and its previous value.
  - Leading edge = synced sclk leaves CPOL; trailing edge = returns to CPOL.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- SCLK constraint: SCLK period ≥ 2*(SYNC_STAGES+2) clk periods. Behaviour is undefined faster than this.
- States: IDLE and ACTIVE.
  - IDLE → ACTIVE on synced cs_n falling.
  - ACTIVE → IDLE on synced cs_n rising.
  - SCLK edges are ignored in IDLE.
- On entering ACTIVE:
  - bit_cnt = 0, miso_oe = 1.
  - tx_req pulses and data_out is captured into tx_word.
  - If CPHA=0, miso is driven with the first bit of tx_word (index DATA_W-1 if MSB_FIRST, else 0) in the same cycle.
- Sample edge:
  - The synced mosi is shifted into rx_shift (MSB_FIRST: shift left, new bit at LSB; else shift right, new bit at MSB).
  - bit_cnt increments.
  - When bit_cnt == DATA_W-1 before the increment:
    - data_in <= completed word (including the current bit); word_sync = 1 next cycle, for one cycle.
    - bit_cnt wraps to 0.
    - tx_req pulses and tx_word <= data_out, ready for the next word.
- Shift edge:
  - miso <= tx_word bit at position bit_cnt (mapped per MSB_FIRST).
  - If CPHA=0 and bit_cnt == 0, the shift edge is ignored; the first bit was already presented.
  - If CPHA=1, the first leading edge presents bit 0 of the word.
- Latency: word_sync asserts exactly 1 clk after the cycle in which the synced completing sample edge is detected.
- Back-to-back words within one frame are supported with no gap cycles. data_in holds its value until the next completed word.
- cs_n rising (ACTIVE → IDLE):
  - If bit_cnt != 0: frame_abort pulses 1 cycle; the partial word is discarded, with no word_sync and no change to data_in.
  - bit_cnt = 0, miso_oe = 0, miso = 0.
- cs_n rising in the same cycle as a completing sample edge: the word completes (word_sync pulses), and frame_abort is not asserted.
- Reset mid-frame: all state returns to reset values immediately. A new frame requires a synced cs_n falling edge after reset release.

Optional Feature:
SPI_BRIDGE_OVERRUN_EN.
- Defined: adds input word_ack (1 bit) and output overrun (1 bit, sticky, reset 0).
  - overrun sets if word_sync fires while the previous word has not yet been acknowledged with word_ack.
  - overrun clears on a word_ack pulse.
  - data_in is still overwritten on every completed word.
- Undefined: neither port exists, and there is no overrun tracking.

Test Plan:
- Mode 0, DATA_W=8, MSB_FIRST: master sends 0xA5 while data_out=0x3C → data_in=0xA5, one word_sync pulse, master receives 0x3C, tx_req pulses twice (frame start + word end).
- Mode 3 (CPOL=1, CPHA=1), DATA_W=16: frame of 0x1234 then 0xBEEF with no gap → two word_sync pulses, data_in=0x1234 then 0xBEEF; MISO returns the two data_out values presented at each tx_req.
- MSB_FIRST=0, mode 1: send 0x01 → data_in=0x01, first MOSI bit was 1; MISO of data_out=0x80 yields bits 0,0,0,0,0,0,0,1.
- Abort: cs_n rises after 5 of 8 bits → frame_abort 1 cycle, no word_sync, data_in unchanged; next full frame 0x5A → data_in=0x5A.
- Reset mid-frame: rst_n low after 3 bits → all outputs 0 and miso_oe=0; new frame 0xFF after release → data_in=0xFF.
- SPI_BRIDGE_OVERRUN_EN: two words without word_ack → overrun=1 after the second word_sync; word_ack pulse → overrun=0.

Source files
------------

// File: rtl/spi_slave_bridge_p_if.sv
// Word-level interface between the SPI slave bridge (master modport) and the register decoder (slave modport).
// With SPI_BRIDGE_OVERRUN_EN defined it also carries word_ack and overrun.
interface spi_slave_bridge_p_if #(
    parameter int DATA_W = 8
);
    logic              word_sync;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              tx_req;
    logic              frame_abort;
`ifdef SPI_BRIDGE_OVERRUN_EN
    logic              word_ack;
    logic              overrun;

    modport master (
        output word_sync, data_in, tx_req, frame_abort, overrun,
        input  data_out, word_ack
    );
    modport slave (
        input  word_sync, data_in, tx_req, frame_abort, overrun,
        output data_out, word_ack
    );
`else
    modport master (
        output word_sync, data_in, tx_req, frame_abort,
        input  data_out
    );
    modport slave (
        input  word_sync, data_in, tx_req, frame_abort,
        output data_out
    );
`endif
endinterface

// File: rtl/spi_slave_bridge_p.sv
// Parametrised SPI slave bridge: all four SPI modes, any word width 2..32, either bit order, clk-domain strobes.
// Optional overrun tracking is enabled with `define SPI_BRIDGE_OVERRUN_EN.
module spi_slave_bridge_p #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    spi_slave_bridge_p_if.master bus
);
    localparam int              CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic            IDLE_LVL  = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam int              FIRST_IDX = (MSB_FIRST != 0) ? DATA_W - 1 : 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // One extra flop beyond the synchroniser depth holds the previous synced level for edge detection.
    logic [SYNC_STAGES:0]   sclk_sync_q;
    logic [SYNC_STAGES:0]   cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_shift_d;
    logic [DATA_W-1:0] tx_word_q;
    logic [DATA_W-1:0] data_in_q;
    logic              miso_q;
    logic              miso_oe_q;
    logic              word_sync_q;
    logic              tx_req_q;
    logic              frame_abort_q;

    logic sclk_now_s;
    logic sclk_prev_s;
    logic lead_s;
    logic trail_s;
    logic sample_s;
    logic shift_s;
    logic cs_fall_s;
    logic cs_rise_s;
    logic mosi_s;
    logic word_done_s;

    function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] cnt);
        if (MSB_FIRST != 0) begin
            bit_index = CNT_LAST - cnt;
        end else begin
            bit_index = cnt;
        end
    endfunction

    // Synchronise the asynchronous SPI pins into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {(SYNC_STAGES+1){IDLE_LVL}};
            cs_sync_q   <= {(SYNC_STAGES+1){1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sclk_now_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sclk_prev_s = sclk_sync_q[SYNC_STAGES];
    assign lead_s      = (sclk_prev_s == IDLE_LVL) && (sclk_now_s != IDLE_LVL);
    assign trail_s     = (sclk_prev_s != IDLE_LVL) && (sclk_now_s == IDLE_LVL);
    assign sample_s    = (CPHA != 0) ? trail_s : lead_s;
    assign shift_s     = (CPHA != 0) ? lead_s : trail_s;
    assign cs_fall_s   = cs_sync_q[SYNC_STAGES] && !cs_sync_q[SYNC_STAGES-1];
    assign cs_rise_s   = !cs_sync_q[SYNC_STAGES] && cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign word_done_s = (state_q == ACTIVE) && sample_s && (bit_cnt_q == CNT_LAST);

    // Receive shifter next value for the current sample edge.
    always_comb begin
        rx_shift_d = rx_shift_q;
        if (MSB_FIRST != 0) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
        end else begin
            rx_shift_d = {mosi_s, rx_shift_q[DATA_W-1:1]};
        end
    end

    // Frame control FSM with all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= CNT_ZERO;
            rx_shift_q    <= {DATA_W{1'b0}};
            tx_word_q     <= {DATA_W{1'b0}};
            data_in_q     <= {DATA_W{1'b0}};
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            word_sync_q   <= 1'b0;
            tx_req_q      <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            word_sync_q   <= 1'b0;
            tx_req_q      <= 1'b0;
            frame_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_q   <= ACTIVE;
                        bit_cnt_q <= CNT_ZERO;
                        miso_oe_q <= 1'b1;
                        tx_req_q  <= 1'b1;
                        tx_word_q <= bus.data_out;
                        miso_q    <= (CPHA == 0) ? bus.data_out[FIRST_IDX] : 1'b0;
                    end
                end
                ACTIVE: begin
                    if (sample_s) begin
                        rx_shift_q <= rx_shift_d;
                        if (bit_cnt_q == CNT_LAST) begin
                            data_in_q   <= rx_shift_d;
                            word_sync_q <= 1'b1;
                            bit_cnt_q   <= CNT_ZERO;
                            tx_req_q    <= 1'b1;
                            tx_word_q   <= bus.data_out;
                            // In CPHA=0 the next word's first bit has no shift edge of its own.
                            if (CPHA == 0) begin
                                miso_q <= bus.data_out[FIRST_IDX];
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        end
                    end else if (shift_s) begin
                        if (!((CPHA == 0) && (bit_cnt_q == CNT_ZERO))) begin
                            miso_q <= tx_word_q[bit_index(bit_cnt_q)];
                        end
                    end
                    if (cs_rise_s) begin
                        state_q       <= IDLE;
                        bit_cnt_q     <= CNT_ZERO;
                        miso_oe_q     <= 1'b0;
                        miso_q        <= 1'b0;
                        frame_abort_q <= (bit_cnt_q != CNT_ZERO) && !word_done_s;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_BRIDGE_OVERRUN_EN
    logic pending_q;
    logic overrun_q;

    // A completed word that arrives before the previous one was acknowledged flags a sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (word_done_s) begin
                pending_q <= 1'b1;
            end else if (bus.word_ack) begin
                pending_q <= 1'b0;
            end
            if (word_done_s && pending_q && !bus.word_ack) begin
                overrun_q <= 1'b1;
            end else if (bus.word_ack) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.overrun = overrun_q;
`endif

    assign miso            = miso_q;
    assign miso_oe         = miso_oe_q;
    assign bus.word_sync   = word_sync_q;
    assign bus.data_in     = data_in_q;
    assign bus.tx_req      = tx_req_q;
    assign bus.frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_bridge_p.sv
// Scoreboard bench for spi_slave_bridge_p: three instances (mode 0 / 8b MSB, mode 3 / 16b MSB, mode 1 / 8b LSB).
`timescale 1ns/1ps
module tb_spi_slave_bridge_p;
    localparam int HALF = 80;
    localparam logic [2:0] CPOLV = 3'b010;
    localparam logic [2:0] CPHAV = 3'b110;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] sclk;
    logic [2:0] cs_n;
    logic mosi;
    wire  [2:0] miso_w;
    wire  [2:0] oe_w;
    wire  [2:0] ws_w;
    wire  [2:0] tx_w;
    wire  [2:0] ab_w;
    logic [31:0] din [3];
    logic [7:0]  dout0;
    logic [15:0] dout1;
    logic [7:0]  dout2;
    logic        ack0;

    always #5 clk = ~clk;

    spi_slave_bridge_p_if #(.DATA_W(8))  bus0 ();
    spi_slave_bridge_p_if #(.DATA_W(16)) bus1 ();
    spi_slave_bridge_p_if #(.DATA_W(8))  bus2 ();

    assign bus0.data_out = dout0;
    assign bus1.data_out = dout1;
    assign bus2.data_out = dout2;
    assign ws_w   = {bus2.word_sync, bus1.word_sync, bus0.word_sync};
    assign tx_w   = {bus2.tx_req, bus1.tx_req, bus0.tx_req};
    assign ab_w   = {bus2.frame_abort, bus1.frame_abort, bus0.frame_abort};
    assign din[0] = {24'h0, bus0.data_in};
    assign din[1] = {16'h0, bus1.data_in};
    assign din[2] = {24'h0, bus2.data_in};
`ifdef SPI_BRIDGE_OVERRUN_EN
    assign bus0.word_ack = ack0;
    assign bus1.word_ack = 1'b0;
    assign bus2.word_ack = 1'b0;
`endif

    spi_slave_bridge_p #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi),
        .miso(miso_w[0]), .miso_oe(oe_w[0]), .bus(bus0.master));
    spi_slave_bridge_p #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi),
        .miso(miso_w[1]), .miso_oe(oe_w[1]), .bus(bus1.master));
    spi_slave_bridge_p #(.DATA_W(8), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[2]), .cs_n(cs_n[2]), .mosi(mosi),
        .miso(miso_w[2]), .miso_oe(oe_w[2]), .bus(bus2.master));

    typedef struct { int dut; logic [31:0] word; } sb_t;
    typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;
    sb_t  sb_q[$];
    chk_t chk_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int tx_cnt [3] = '{0, 0, 0};
    int ab_cnt [3] = '{0, 0, 0};
    int ws_cnt [3] = '{0, 0, 0};
    int b_tx, b_ws, b_ab;
    logic [63:0] rx;

    // Monitor: checks each word_sync against the scoreboard and drains queued directed checks.
    always @(negedge clk) begin : monitor
        sb_t  e;
        chk_t c;
        for (int d = 0; d < 3; d++) begin
            if (tx_w[d]) tx_cnt[d]++;
            if (ab_w[d]) ab_cnt[d]++;
            if (ws_w[d]) begin
                ws_cnt[d]++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL word_sync dut%0d: got unexpected word %h, required no word", d, din[d]);
                end else begin
                    e = sb_q.pop_front();
                    if (e.dut != d || e.word != din[d]) begin
                        n_bad++;
                        $display("FAIL data_in dut%0d: got %h, required dut%0d %h", d, din[d], e.dut, e.word);
                    end
                end
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, required %h", c.name, c.act, c.exp);
            end
        end
    end

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_word(input int d, input logic [31:0] w);
        sb_t e;
        e.dut  = d;
        e.word = w;
        sb_q.push_back(e);
    endtask

    task automatic snap(input int d);
        b_tx = tx_cnt[d];
        b_ws = ws_cnt[d];
        b_ab = ab_cnt[d];
    endtask

    task automatic deltas(input string tag, input int d, input int etx, input int ews, input int eab);
        expect_eq({tag, " tx_req count"}, 64'(tx_cnt[d] - b_tx), 64'(etx));
        expect_eq({tag, " word_sync count"}, 64'(ws_cnt[d] - b_ws), 64'(ews));
        expect_eq({tag, " frame_abort count"}, 64'(ab_cnt[d] - b_ab), 64'(eab));
    endtask

    function automatic logic [63:0] wire_bits(input logic [31:0] w, input int width, input logic msb);
        wire_bits = 64'h0;
        for (int i = 0; i < width; i++) begin
            wire_bits[i] = msb ? w[width-1-i] : w[i];
        end
    endfunction

    // SPI master: bit i of tx_bits/rx_bits is the i-th bit on the wire.
    task automatic spi_xfer(input int d, input int nbits, input logic [63:0] tx_bits, output logic [63:0] rx_bits);
        rx_bits = 64'h0;
        if (CPHAV[d] == 1'b0) mosi = tx_bits[0];
        cs_n[d] = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            sclk[d] = ~CPOLV[d];
            if (CPHAV[d] == 1'b0) rx_bits[i] = miso_w[d];
            else mosi = tx_bits[i];
            #(HALF);
            sclk[d] = CPOLV[d];
            if (CPHAV[d] == 1'b0) mosi = tx_bits[i+1];
            else rx_bits[i] = miso_w[d];
            #(HALF);
        end
        cs_n[d] = 1'b1;
        #(4*HALF);
    endtask

    initial begin
        rst_n = 1'b0;
        cs_n  = 3'b111;
        sclk  = CPOLV;
        mosi  = 1'b0;
        ack0  = 1'b0;
        dout0 = 8'h00;
        dout1 = 16'h0000;
        dout2 = 8'h00;
        #23;
        for (int d = 0; d < 3; d++) begin
            expect_eq($sformatf("reset outputs dut%0d", d),
                      {27'h0, miso_w[d], oe_w[d], ws_w[d], tx_w[d], ab_w[d], din[d]}, 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, 8-bit MSB first
        dout0 = 8'h3C;
        snap(0);
        expect_word(0, 32'hA5);
        spi_xfer(0, 8, wire_bits(32'hA5, 8, 1'b1), rx);
        expect_eq("mode0 miso stream", rx, wire_bits(32'h3C, 8, 1'b1));
        expect_eq("mode0 data_in", 64'(din[0]), 64'hA5);
        expect_eq("mode0 miso_oe after frame", 64'(oe_w[0]), 64'h0);
        deltas("mode0", 0, 2, 1, 0);

        // Mode 3, 16-bit, two back-to-back words; data_out changes between the two tx_req pulses
        dout1 = 16'hCAFE;
        snap(1);
        expect_word(1, 32'h1234);
        expect_word(1, 32'hBEEF);
        fork
            spi_xfer(1, 32, wire_bits(32'h1234, 16, 1'b1) | (wire_bits(32'hBEEF, 16, 1'b1) << 16), rx);
            begin
                #1000;
                dout1 = 16'h0F0F;
            end
        join
        expect_eq("mode3 miso stream", rx, wire_bits(32'hCAFE, 16, 1'b1) | (wire_bits(32'h0F0F, 16, 1'b1) << 16));
        expect_eq("mode3 data_in", 64'(din[1]), 64'hBEEF);
        deltas("mode3", 1, 3, 2, 0);

        // Mode 1, LSB first
        dout2 = 8'h80;
        snap(2);
        expect_word(2, 32'h01);
        spi_xfer(2, 8, wire_bits(32'h01, 8, 1'b0), rx);
        expect_eq("lsb miso stream", rx, 64'h80);
        expect_eq("lsb data_in", 64'(din[2]), 64'h01);
        deltas("lsb", 2, 2, 1, 0);

        // Abort after 5 of 8 bits, then a full frame
        dout0 = 8'h00;
        snap(0);
        spi_xfer(0, 5, wire_bits(32'hFF, 8, 1'b1), rx);
        expect_eq("abort data_in unchanged", 64'(din[0]), 64'hA5);
        deltas("abort", 0, 1, 0, 1);
        snap(0);
        expect_word(0, 32'h5A);
        spi_xfer(0, 8, wire_bits(32'h5A, 8, 1'b1), rx);
        expect_eq("after abort data_in", 64'(din[0]), 64'h5A);
        deltas("after abort", 0, 2, 1, 0);

        // Reset in the middle of a frame
        dout0 = 8'hFF;
        snap(0);
        fork
            spi_xfer(0, 8, wire_bits(32'h33, 8, 1'b1), rx);
            begin
                #(HALF + 6*HALF + 40);
                rst_n = 1'b0;
                #20;
                expect_eq("midframe reset outputs",
                          {27'h0, miso_w[0], oe_w[0], ws_w[0], tx_w[0], ab_w[0], din[0]}, 64'h0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_eq("midframe reset word_sync count", 64'(ws_cnt[0] - b_ws), 64'h0);
        expect_eq("midframe reset frame_abort count", 64'(ab_cnt[0] - b_ab), 64'h0);
        dout0 = 8'h81;
        snap(0);
        expect_word(0, 32'hFF);
        spi_xfer(0, 8, wire_bits(32'hFF, 8, 1'b1), rx);
        expect_eq("post reset data_in", 64'(din[0]), 64'hFF);
        expect_eq("post reset miso stream", rx, wire_bits(32'h81, 8, 1'b1));
        deltas("post reset", 0, 2, 1, 0);

`ifdef SPI_BRIDGE_OVERRUN_EN
        @(negedge clk);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        expect_eq("overrun cleared by ack", 64'(bus0.overrun), 64'h0);
        expect_word(0, 32'h11);
        spi_xfer(0, 8, wire_bits(32'h11, 8, 1'b1), rx);
        expect_eq("overrun after first word", 64'(bus0.overrun), 64'h0);
        expect_word(0, 32'h22);
        spi_xfer(0, 8, wire_bits(32'h22, 8, 1'b1), rx);
        expect_eq("overrun after second word", 64'(bus0.overrun), 64'h1);
        expect_eq("overrun data_in overwritten", 64'(din[0]), 64'h22);
        @(negedge clk);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        #1;
        expect_eq("overrun after ack", 64'(bus0.overrun), 64'h0);
`endif

        repeat (4) @(negedge clk);
        expect_eq("scoreboard drained", 64'(sb_q.size()), 64'h0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
